// File: rtl/us_fault_pkg.sv
// Shared ping states and report text for the ultrasonic fault monitor.
package us_fault_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEAS, EVAL, HOLD} ping_state_e;

  localparam int MSG_LEN = 10;
  localparam int CH_IDX = 7;
  localparam logic [7:0] ASCII_ONE = 8'h31;
  // Byte 0 is the leftmost character; CH_IDX is overwritten with the channel digit.
  localparam logic [0:MSG_LEN-1][7:0] MSG_ROM = "FIM-CSU1-#";
endpackage

// File: rtl/us_msg_sender.sv
// Pending-fault arbitration and byte streaming of the channel-tagged report.
module us_msg_sender
  import us_fault_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int CH_W = 1
) (
  input  logic            clk_50M,
  input  logic            rst_n,
  input  logic            node_flag,
  input  logic            fault_set,
  input  logic [CH_W-1:0] fault_idx,
  input  logic            tx_ready,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  output logic            busy
);
  localparam int IDX_W = $clog2(MSG_LEN);

  logic [N_CH-1:0]  pend, pend_n;
  logic             permit;
  logic [CH_W-1:0]  cur_ch, low_ch;
  logic [IDX_W-1:0] idx;
  logic             accept, last, start;

  assign accept   = busy && tx_ready;
  assign last     = accept && (idx == IDX_W'(MSG_LEN-1));
  assign start    = permit && !busy && (|pend);
  assign tx_valid = busy;

  always_comb begin
    low_ch = '0;
    for (int i = N_CH-1; i >= 0; i--)
      if (pend[i]) low_ch = CH_W'(i);
  end

  // Clear the reported channel first so a fault landing in the same cycle re-arms it.
  always_comb begin
    pend_n = pend;
    for (int i = 0; i < N_CH; i++) begin
      if (last && cur_ch == CH_W'(i)) pend_n[i] = 1'b0;
      if (fault_set && fault_idx == CH_W'(i)) pend_n[i] = 1'b1;
    end
  end

  always_comb begin
    tx_data = '0;
    if (busy)
      tx_data = (idx == IDX_W'(CH_IDX)) ? ASCII_ONE + 8'(cur_ch) : MSG_ROM[idx];
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      permit <= 1'b0;
      busy   <= 1'b0;
      cur_ch <= '0;
      idx    <= '0;
    end else begin
      pend <= pend_n;
      if (node_flag)  permit <= 1'b1;
      else if (last)  permit <= 1'b0;
      if (start) begin
        busy   <= 1'b1;
        cur_ch <= low_ch;
        idx    <= '0;
      end else if (last) begin
        busy <= 1'b0;
        idx  <= '0;
      end else if (accept) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end
endmodule

// File: rtl/us_fault_monitor.sv
// Round-robin ultrasonic ping/measure FSM with fault window check feeding the report sender.
module us_fault_monitor
  import us_fault_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 16,
  parameter int TRIG_CYC    = 500,
  parameter int WIN_LO      = 17000,
  parameter int WIN_HI      = 19000,
  parameter int TIMEOUT_CYC = 60000,
  parameter int PERIOD_CYC  = 3000000,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             key_flag,
  input  logic             node_flag,
  input  logic [N_CH-1:0]  us_echo,
  output logic [N_CH-1:0]  us_trig,
  output logic             fault_detect,
  output logic [CH_W-1:0]  fault_ch,
  output logic [CNT_W-1:0] echo_width,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy
);
  logic [N_CH-1:0]  echo_s1, echo_s2;
  logic             echo;
  ping_state_e      state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      per_cnt;
  logic [CH_W-1:0]  ch;
  logic             trig_done, rise_to, meas_done, period_done, in_win;

  assign echo        = echo_s2[ch];
  assign trig_done   = cnt == CNT_W'(TRIG_CYC-1);
  assign rise_to     = cnt == CNT_W'(TIMEOUT_CYC-1);
  assign meas_done   = !echo || (cnt == CNT_W'(TIMEOUT_CYC));
  assign period_done = per_cnt >= 32'(PERIOD_CYC-1);
  assign in_win      = (cnt > CNT_W'(WIN_LO)) && (cnt < CNT_W'(WIN_HI));

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      state   <= IDLE;
    end else begin
      echo_s1 <= us_echo;
      echo_s2 <= echo_s1;
      state   <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (!key_flag) state_n = IDLE;
    else begin
      case (state)
        IDLE:      state_n = TRIG;
        TRIG:      if (trig_done) state_n = WAIT_RISE;
        WAIT_RISE: if (echo) state_n = MEAS; else if (rise_to) state_n = HOLD;
        MEAS:      if (meas_done) state_n = EVAL;
        EVAL:      state_n = HOLD;
        HOLD:      if (period_done) state_n = TRIG;
        default:   state_n = IDLE;
      endcase
    end
  end

  // per_cnt restarts on every TRIG entry so HOLD enforces start-to-start spacing.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      per_cnt      <= '0;
      ch           <= '0;
      us_trig      <= '0;
      fault_detect <= 1'b0;
      fault_ch     <= '0;
      echo_width   <= '0;
    end else begin
      us_trig      <= '0;
      fault_detect <= 1'b0;
      per_cnt      <= per_cnt + 32'd1;
      if (!key_flag) begin
        cnt     <= '0;
        per_cnt <= '0;
      end else begin
        case (state)
          IDLE: per_cnt <= '0;
          TRIG: begin
            us_trig[ch] <= 1'b1;
            cnt <= trig_done ? '0 : cnt + CNT_W'(1);
          end
          WAIT_RISE: begin
            if (echo) cnt <= CNT_W'(1);
            else if (rise_to) begin
              cnt        <= '0;
              echo_width <= '0;
            end else cnt <= cnt + CNT_W'(1);
          end
          MEAS: if (!meas_done) cnt <= cnt + CNT_W'(1);
          EVAL: begin
            echo_width <= cnt;
            cnt        <= '0;
            if (in_win) begin
              fault_detect <= 1'b1;
              fault_ch     <= ch;
            end
          end
          HOLD: if (period_done) begin
            per_cnt <= '0;
            ch      <= (ch == CH_W'(N_CH-1)) ? '0 : ch + CH_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  us_msg_sender #(.N_CH(N_CH), .CH_W(CH_W)) u_sender (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .node_flag(node_flag),
    .fault_set(fault_detect),
    .fault_idx(fault_ch),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .busy     (busy)
  );
endmodule

// File: doc/us_fault_monitor.md
# us_fault_monitor

Parametrised multi-channel ultrasonic fault monitor for the line-following bot. It pings N_CH ultrasonic sensors one at a time in round-robin and measures each echo pulse width in clk_50M cycles. A width inside the fault window raises a per-channel fault. When the path controller grants a node via node_flag, the block streams an ASCII fault report, tagged with the channel number, to the Bluetooth UART through a valid/ready byte handshake.

## Interface
Parameters:
- N_CH, 2: number of sensor channels (1..9).
- CNT_W, 16: echo width counter bits.
- TRIG_CYC, 500: trigger high time in cycles (10 us at 50 MHz).
- WIN_LO, 17000: fault window lower bound, exclusive.
- WIN_HI, 19000: fault window upper bound, exclusive.
- TIMEOUT_CYC, 60000: maximum wait for the echo rising edge and maximum measured width.
- PERIOD_CYC, 3000000: minimum start-to-start spacing of consecutive pings (60 ms).

Ports:
- clk_50M, in, 1: system clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- key_flag, in, 1: scan enable.
- node_flag, in, 1: node reached; grants message permission.
- us_echo, in, N_CH: raw echo inputs.
- us_trig, out, N_CH: trigger outputs.
- fault_detect, out, 1: one-cycle pulse on each fault.
- fault_ch, out, $clog2(N_CH) (min 1): channel index of the fault, valid while fault_detect is high.
- echo_width, out, CNT_W: last completed measurement for any channel; 0 on timeout.
- tx_data, out, 8: report byte.
- tx_valid, out, 1: tx_data valid.
- tx_ready, in, 1: UART accepts the byte.
- busy, out, 1: report transmission in progress.

## Operation
- Each us_echo bit passes through a 2-flop synchroniser before any use.
- Ping FSM states and transitions:
  - IDLE: when key_flag=1, go to TRIG for channel ch.
  - TRIG: hold us_trig[ch] high for exactly TRIG_CYC cycles, then go to WAIT_RISE.
  - WAIT_RISE: on synchronised echo high, go to MEAS. After TIMEOUT_CYC cycles with no echo, set echo_width=0 and go to HOLD with no fault.
  - MEAS: count cycles while echo is high. The counter saturates at TIMEOUT_CYC; saturation forces exit to EVAL.
  - EVAL: echo_width<=count. If WIN_LO<count<WIN_HI, pulse fault_detect, drive fault_ch=ch, and set pend[ch]. Go to HOLD.
  - HOLD: wait until PERIOD_CYC cycles have elapsed since TRIG entry, then ch<=(ch+1) mod N_CH and go to TRIG.
- The fault decision uses the current measurement, not the previous one.
- key_flag=0 in any ping state: next cycle, the FSM goes to IDLE, all us_trig go low, counters clear, and ch is kept. pend and the sender are not affected.
- Report sender:
  - permit is set by node_flag and cleared when a report ends. If node_flag and end-of-report occur in the same cycle, the set wins.
  - When permit=1, the sender is idle, and some pend bit is set, it selects the lowest pending channel k and sends MSG_LEN bytes from MSG_ROM. Byte CH_IDX is replaced by ASCII '1'+k. Default text: "FIM-CSU1-#".
  - pend[k] clears after the last byte is accepted.
  - A fault on channel k while k is being reported re-sets pend[k], so the report repeats later.
- Byte handshake: tx_valid and tx_data stay stable until a cycle with tx_valid&&tx_ready. The next byte may be presented in the following cycle.

## Timing
- Reset values: us_trig=0, fault_detect=0, fault_ch=0, echo_width=0, tx_data=0, tx_valid=0, busy=0. Also ch=0, pend=0, permit=0, FSM=IDLE.
- us_trig[ch] rises 1 cycle after IDLE→TRIG and is high for exactly TRIG_CYC cycles.
- A raw echo pulse of W cycles yields count=W, within ±1 cycle of synchroniser skew.
- fault_detect asserts 4 cycles after the raw echo falling edge: 2 sync, 1 edge detect into EVAL, 1 register.
- tx_valid asserts 1 cycle after the start condition. busy is high from that cycle until the cycle after the last accept.
- Report length with tx_ready tied high: MSG_LEN cycles.
- Asserting rst_n low mid-report aborts the report immediately. No partial state survives.

## Structure
- Package us_fault_pkg: ping state enum {IDLE, TRIG, WAIT_RISE, MEAS, EVAL, HOLD}, MSG_LEN=10, MSG_ROM byte array, CH_IDX=7, ASCII_ONE=8'h31.
- Sub-module us_msg_sender: pend/permit arbitration, byte index, and valid/ready handshake. The top module holds the synchronisers and the ping FSM.

## Test plan
- Test config N_CH=2, PERIOD_CYC=40000. Echo on ch0 of 18000 cycles → fault_detect pulse, fault_ch=0, echo_width≈18000, pend=2'b01. No tx_valid until node_flag.
- Echo widths of 17000 and 19000 cycles → no fault (exclusive bounds). 17001 → fault.
- No echo → after TIMEOUT_CYC, echo_width=0, no fault, and the next ping goes to ch1.
- Faults on ch1 then ch0, then a node_flag pulse, tx_ready=1 → "FIM-CSU1-#" first (lowest pending channel, ch0), then "FIM-CSU2-#" only after a second node_flag.
- tx_ready toggled 1 of every 3 cycles → tx_data is stable while valid&&!ready, and all 10 bytes arrive in order.
- key_flag dropped mid-TRIG → us_trig=0 next cycle. rst_n low mid-report → tx_valid=0 and busy=0 asynchronously.
